cordic_sched: RTL and testbench

//  Time-shares one fixed-latency CORDIC pipeline (pre-stage + rotation stages) among NCH requesters.
//  - Round-robin arbitration issues at most one operand set per cycle into the pipeline.
//  - The channel ID of each issued operation is carried in a tag delay line matched to the pipeline latency.
//  - Each returning result is tagged with its channel. Sits between per-channel NCO/phase sources and the CORDIC core.

---
 rtl/cordic_sched_if.sv | 49 ++++
 rtl/cordic_sched.sv | 158 +++++++++++++++
 tb/tb_cordic_sched.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sched_if.sv
// Bundle of requester, CORDIC-core and tagged-result signals around cordic_sched.
// Handshake: a request transfers on a cycle where req_vld[i] & req_rdy[i]; req_rdy never depends on req_x/y/z.
interface cordic_sched_if #(
   parameter int NCH = 4,
   parameter int CHW = 2,
   parameter int IDW = 12,
   parameter int ODW = 14,
   parameter int AW  = 20
);
   logic [NCH-1:0]     ch_en;
   logic [NCH-1:0]     req_vld;
   logic [NCH-1:0]     req_rdy;
   logic [NCH*IDW-1:0] req_x;
   logic [NCH*IDW-1:0] req_y;
   logic [NCH*AW-1:0]  req_z;

   logic               cd_dv;
   logic [IDW-1:0]     cd_x;
   logic [IDW-1:0]     cd_y;
   logic [AW-1:0]      cd_z;

   logic               cd_res_dv;
   logic [ODW-1:0]     cd_res_x;
   logic [ODW-1:0]     cd_res_y;
   logic [AW-1:0]      cd_res_z;

   logic               res_vld;
   logic [CHW-1:0]     res_ch;
   logic [ODW-1:0]     res_x;
   logic [ODW-1:0]     res_y;
   logic [AW-1:0]      res_z;
   logic               busy;
   logic               tag_err;
   logic               state_dbg;

   modport master (
      output ch_en, req_vld, req_x, req_y, req_z,
      output cd_res_dv, cd_res_x, cd_res_y, cd_res_z,
      input  req_rdy, cd_dv, cd_x, cd_y, cd_z,
      input  res_vld, res_ch, res_x, res_y, res_z, busy, tag_err, state_dbg
   );

   modport slave (
      input  ch_en, req_vld, req_x, req_y, req_z,
      input  cd_res_dv, cd_res_x, cd_res_y, cd_res_z,
      output req_rdy, cd_dv, cd_x, cd_y, cd_z,
      output res_vld, res_ch, res_x, res_y, res_z, busy, tag_err, state_dbg
   );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC pipeline among NCH channels,
// tagging each returning result with its channel through a latency-matched tag line.
module cordic_sched #(
   parameter int NCH = 4,
   parameter int CHW = 2,
   parameter int IDW = 12,
   parameter int ODW = 14,
   parameter int AW  = 20,
   parameter int LAT = 16
) (
   input logic           clk,
   input logic           rst,
   cordic_sched_if.slave bus
);

   localparam int FCW = $clog2(LAT + 1);

   typedef enum logic {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t         state, state_nxt;
   logic [FCW-1:0] flush_cnt, flush_cnt_nxt;
   logic           flushing;

   logic [CHW-1:0] ptr;
   logic [NCH-1:0] eligible;
   logic [NCH-1:0] grant;
   logic           grant_any;
   logic [CHW-1:0] grant_ch;
   int             arb_idx;

   logic [CHW-1:0] cd_ch;
   logic [LAT-1:0] tag_vld;
   logic [CHW-1:0] tag_ch [LAT];
   logic           tail_vld;
   logic [CHW-1:0] tail_ch;

   // Flush window: after reset the core may still return results issued before reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FLUSH;
         flush_cnt <= FCW'(LAT);
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      case (state)
         ST_FLUSH: begin
            flush_cnt_nxt = flush_cnt - FCW'(1);
            if (flush_cnt == FCW'(1)) state_nxt = ST_RUN;
         end
         ST_RUN: flush_cnt_nxt = '0;
         default: begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FCW'(LAT);
         end
      endcase
   end

   assign flushing      = (flush_cnt != '0);
   assign bus.state_dbg = state;

   // First eligible channel at or above the pointer, wrapping.
   always_comb begin
      eligible  = bus.req_vld & bus.ch_en;
      grant     = '0;
      grant_any = 1'b0;
      grant_ch  = '0;
      arb_idx   = 0;
      for (int k = 0; k < NCH; k++) begin
         arb_idx = int'(ptr) + k;
         if (arb_idx >= NCH) arb_idx = arb_idx - NCH;
         if (!grant_any && eligible[arb_idx]) begin
            grant_any = 1'b1;
            grant_ch  = CHW'(arb_idx);
         end
      end
      if (rst || flushing) grant_any = 1'b0;
      if (grant_any) grant[grant_ch] = 1'b1;
   end

   assign bus.req_rdy = grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (int'(grant_ch) == NCH - 1) ? '0 : grant_ch + CHW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.cd_dv <= 1'b0;
         bus.cd_x  <= '0;
         bus.cd_y  <= '0;
         bus.cd_z  <= '0;
         cd_ch     <= '0;
      end else begin
         bus.cd_dv <= grant_any;
         if (grant_any) begin
            bus.cd_x <= bus.req_x[int'(grant_ch)*IDW +: IDW];
            bus.cd_y <= bus.req_y[int'(grant_ch)*IDW +: IDW];
            bus.cd_z <= bus.req_z[int'(grant_ch)*AW +: AW];
            cd_ch    <= grant_ch;
         end
      end
   end

   // Stage 0 takes the issue register, so the tail lines up with cd_res_dv LAT cycles after cd_dv.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld <= '0;
         for (int i = 0; i < LAT; i++) tag_ch[i] <= '0;
      end else begin
         tag_vld   <= {tag_vld[LAT-2:0], bus.cd_dv};
         tag_ch[0] <= cd_ch;
         for (int i = 1; i < LAT; i++) tag_ch[i] <= tag_ch[i-1];
      end
   end

   assign tail_vld = tag_vld[LAT-1];
   assign tail_ch  = tag_ch[LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.res_vld <= 1'b0;
         bus.res_ch  <= '0;
         bus.res_x   <= '0;
         bus.res_y   <= '0;
         bus.res_z   <= '0;
         bus.tag_err <= 1'b0;
      end else begin
         bus.res_vld <= 1'b0;
         if (!flushing) begin
            if (tail_vld && bus.cd_res_dv) begin
               bus.res_vld <= 1'b1;
               bus.res_ch  <= tail_ch;
               bus.res_x   <= bus.cd_res_x;
               bus.res_y   <= bus.cd_res_y;
               bus.res_z   <= bus.cd_res_z;
            end else if (tail_vld != bus.cd_res_dv) begin
               bus.tag_err <= 1'b1;
            end
         end
      end
   end

   assign bus.busy = flushing | bus.cd_dv | (|tag_vld);

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: random requesters, a behavioural CORDIC core with fixed latency,
// and a reference arbiter/scoreboard predicting grants and tagged results.
module tb_cordic_sched;
   localparam int NCH = 4;
   localparam int CHW = 2;
   localparam int IDW = 12;
   localparam int ODW = 14;
   localparam int AW  = 20;
   localparam int LAT = 16;
   localparam int RW  = 32 + CHW + 2*ODW + AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   int n_cmp = 0;
   int n_bad = 0;
   int flush_left = 0;
   int m_ptr = 0;
   int inject_at = -1;
   logic          z_ovr = 1'b0;
   logic [AW-1:0] z_ovr_val = '0;

   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] got_q[$];

   logic           ring_dv [64];
   logic [ODW-1:0] ring_x  [64];
   logic [ODW-1:0] ring_y  [64];
   logic [AW-1:0]  ring_z  [64];

   cordic_sched_if #(.NCH(NCH), .CHW(CHW), .IDW(IDW), .ODW(ODW), .AW(AW)) bus ();

   cordic_sched #(.NCH(NCH), .CHW(CHW), .IDW(IDW), .ODW(ODW), .AW(AW), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_vld = '0;
      bus.ch_en   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      flush_left = LAT;
      m_ptr = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   // ---------------- behavioural CORDIC core ----------------
   initial begin
      int s;
      int t;
      for (int i = 0; i < 64; i++) ring_dv[i] = 1'b0;
      bus.cd_res_dv = 1'b0;
      bus.cd_res_x  = '0;
      bus.cd_res_y  = '0;
      bus.cd_res_z  = '0;
      forever begin
         @(negedge clk);
         s = cyc % 64;
         bus.cd_res_dv = ring_dv[s] | (cyc == inject_at);
         bus.cd_res_x  = ring_x[s];
         bus.cd_res_y  = ring_y[s];
         bus.cd_res_z  = ring_z[s];
         ring_dv[s] = 1'b0;
         if (bus.cd_dv === 1'b1) begin
            t = (cyc + LAT) % 64;
            ring_dv[t] = 1'b1;
            ring_x[t]  = {2'b01, bus.cd_x};
            ring_y[t]  = {2'b10, bus.cd_y};
            ring_z[t]  = ~bus.cd_z;
         end
      end
   end

   // ---------------- result recorder ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (bus.res_vld === 1'b1)
            got_q.push_back({32'(cyc), bus.res_ch, bus.res_x, bus.res_y, bus.res_z});
      end
   end

   // ---------------- driver + reference model ----------------
   task automatic drive_cycle(input logic [NCH-1:0] vld, input logic [NCH-1:0] en,
                              output logic [NCH-1:0] got_rdy, output logic [NCH-1:0] exp_rdy);
      logic [IDW-1:0] ox [NCH];
      logic [IDW-1:0] oy [NCH];
      logic [AW-1:0]  oz [NCH];
      int c;
      int gch;
      @(negedge clk);
      if (flush_left > 0) flush_left--;
      for (int i = 0; i < NCH; i++) begin
         ox[i] = IDW'($urandom);
         oy[i] = IDW'($urandom);
         oz[i] = AW'($urandom);
         if (z_ovr && i == 2) oz[i] = z_ovr_val;
         bus.req_x[i*IDW +: IDW] = ox[i];
         bus.req_y[i*IDW +: IDW] = oy[i];
         bus.req_z[i*AW +: AW]   = oz[i];
      end
      bus.req_vld = vld;
      bus.ch_en   = en;
      #1;
      got_rdy = bus.req_rdy;
      exp_rdy = '0;
      gch = -1;
      if (flush_left == 0 && !rst) begin
         for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (gch < 0 && vld[c] && en[c]) gch = c;
         end
         if (gch >= 0) begin
            exp_rdy[gch] = 1'b1;
            m_ptr = (gch + 1) % NCH;
            exp_q.push_back({32'(cyc + LAT + 2), CHW'(gch), {2'b01, ox[gch]}, {2'b10, oy[gch]}, ~oz[gch]});
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [NCH-1:0] g, e;
      #1;
      n_cmp++; if (bus.cd_dv !== 1'b0) begin n_bad++; $display("FAIL rst_cd_dv: got %h want 0", bus.cd_dv); end
      n_cmp++; if (bus.cd_z !== '0) begin n_bad++; $display("FAIL rst_cd_z: got %h want 0", bus.cd_z); end
      n_cmp++; if (bus.res_vld !== 1'b0) begin n_bad++; $display("FAIL rst_res_vld: got %h want 0", bus.res_vld); end
      n_cmp++; if (bus.res_x !== '0) begin n_bad++; $display("FAIL rst_res_x: got %h want 0", bus.res_x); end
      n_cmp++; if (bus.tag_err !== 1'b0) begin n_bad++; $display("FAIL rst_tag_err: got %h want 0", bus.tag_err); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %h want 1", bus.busy); end
      for (int i = 0; i < LAT; i++) begin
         drive_cycle('1, '1, g, e);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL flush_rdy cyc %0d: got %b want %b", cyc, g, e); end
      end
      n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL first_grant: got %b want 0001", g); end
   endtask

   task automatic test_round_robin();
      logic [NCH-1:0] g, e;
      logic [RW-1:0] gw, ew;
      for (int i = 0; i < 12; i++) begin
         drive_cycle('1, '1, g, e);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rr_grant cyc %0d: got %b want %b", cyc, g, e); end
      end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy: got %h want 1", bus.busy); end
      for (int i = 0; i < LAT + 8 && got_q.size() < exp_q.size(); i++) drive_cycle('0, '1, g, e);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL rr_count: got %0d results want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         gw = got_q.pop_front();
         ew = exp_q.pop_front();
         n_cmp++; if (gw !== ew) begin n_bad++; $display("FAIL rr_result: got %h want %h", gw, ew); end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_single();
      logic [NCH-1:0] g, e;
      logic [RW-1:0] gw, ew;
      int c0;
      z_ovr = 1'b1;
      z_ovr_val = 20'h40000;
      drive_cycle(4'b0100, 4'hF, g, e);
      z_ovr = 1'b0;
      c0 = cyc;
      n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", g); end
      drive_cycle('0, '1, g, e);
      n_cmp++; if (bus.cd_dv !== 1'b1) begin n_bad++; $display("FAIL single_cd_dv: got %h want 1", bus.cd_dv); end
      n_cmp++; if (bus.cd_z !== 20'h40000) begin n_bad++; $display("FAIL single_cd_z: got %h want 40000", bus.cd_z); end
      drive_cycle('0, '1, g, e);
      n_cmp++; if (bus.cd_dv !== 1'b0) begin n_bad++; $display("FAIL single_cd_dv_off: got %h want 0", bus.cd_dv); end
      n_cmp++; if (bus.cd_z !== 20'h40000) begin n_bad++; $display("FAIL single_cd_z_hold: got %h want 40000", bus.cd_z); end
      for (int i = 0; i < LAT + 8 && got_q.size() < exp_q.size(); i++) drive_cycle('0, '1, g, e);
      n_cmp++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         n_bad++; $display("FAIL single_count: got %0d results want 1", got_q.size());
      end else begin
         gw = got_q.pop_front();
         ew = exp_q.pop_front();
         n_cmp++;
         if (gw[RW-1 -: 32] !== 32'(c0 + LAT + 2) || gw[RW-33 -: CHW] !== 2'd2) begin
            n_bad++; $display("FAIL single_timing: got cyc %0d ch %0d want cyc %0d ch 2", gw[RW-1 -: 32], gw[RW-33 -: CHW], c0 + LAT + 2);
         end
         n_cmp++; if (gw !== ew) begin n_bad++; $display("FAIL single_result: got %h want %h", gw, ew); end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_mask();
      logic [NCH-1:0] g, e;
      for (int i = 0; i < 6; i++) begin
         drive_cycle('1, 4'b1011, g, e);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL mask_grant cyc %0d: got %b want %b", cyc, g, e); end
         n_cmp++; if (g[2] !== 1'b0) begin n_bad++; $display("FAIL mask_ch2: got %b want 0", g[2]); end
      end
   endtask

   task automatic test_ptr();
      logic [NCH-1:0] g, e;
      drive_cycle(4'b0100, '1, g, e);
      n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL ptr_setup: got %b want 0100", g); end
      drive_cycle(4'b0010, '1, g, e);
      n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL ptr_wrap_grant: got %b want 0010", g); end
      drive_cycle('1, '1, g, e);
      n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL ptr_after: got %b want 0100", g); end
   endtask

   task automatic test_back_to_back();
      logic [NCH-1:0] g, e, v, en;
      logic [RW-1:0] gw, ew;
      for (int i = 0; i < 300; i++) begin
         v  = NCH'($urandom_range(0, 15));
         en = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
         drive_cycle(v, en, g, e);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_grant cyc %0d: got %b want %b", cyc, g, e); end
      end
      for (int i = 0; i < LAT + 8 && got_q.size() < exp_q.size(); i++) drive_cycle('0, '1, g, e);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL b2b_count: got %0d results want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         gw = got_q.pop_front();
         ew = exp_q.pop_front();
         n_cmp++; if (gw !== ew) begin n_bad++; $display("FAIL b2b_result: got %h want %h", gw, ew); end
      end
      exp_q.delete();
      got_q.delete();
      repeat (3) drive_cycle('0, '1, g, e);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy: got %h want 0", bus.busy); end
   endtask

   task automatic test_stray();
      logic [NCH-1:0] g, e;
      inject_at = cyc + 1;
      drive_cycle('0, '1, g, e);
      drive_cycle('0, '1, g, e);
      n_cmp++; if (bus.tag_err !== 1'b1) begin n_bad++; $display("FAIL stray_tag_err: got %h want 1", bus.tag_err); end
      n_cmp++; if (bus.res_vld !== 1'b0) begin n_bad++; $display("FAIL stray_res_vld: got %h want 0", bus.res_vld); end
      repeat (5) drive_cycle('0, '1, g, e);
      n_cmp++; if (bus.tag_err !== 1'b1) begin n_bad++; $display("FAIL stray_sticky: got %h want 1", bus.tag_err); end
      n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL stray_results: got %0d want 0", got_q.size()); end
   endtask

   task automatic test_reset_inflight();
      logic [NCH-1:0] g, e;
      do_reset();
      #1;
      n_cmp++; if (bus.tag_err !== 1'b0) begin n_bad++; $display("FAIL rif_clear: got %h want 0", bus.tag_err); end
      repeat (LAT) drive_cycle('0, '1, g, e);
      for (int i = 0; i < 5; i++) begin
         drive_cycle('1, '1, g, e);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rif_issue: got %b want %b", g, e); end
      end
      do_reset();
      for (int i = 0; i < LAT; i++) begin
         drive_cycle('1, '1, g, e);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rif_rdy cyc %0d: got %b want %b", cyc, g, e); end
         n_cmp++; if (bus.res_vld !== 1'b0) begin n_bad++; $display("FAIL rif_res_vld cyc %0d: got %h want 0", cyc, bus.res_vld); end
         n_cmp++; if (bus.tag_err !== 1'b0) begin n_bad++; $display("FAIL rif_tag_err cyc %0d: got %h want 0", cyc, bus.tag_err); end
      end
      n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL rif_resume: got %b want 0001", g); end
      n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL rif_swallow: got %0d want 0", got_q.size()); end
   endtask

   initial begin
      bus.req_vld = '0;
      bus.ch_en   = '0;
      bus.req_x   = '0;
      bus.req_y   = '0;
      bus.req_z   = '0;
      do_reset();
      test_reset();
      test_round_robin();
      test_single();
      test_mask();
      test_ptr();
      test_back_to_back();
      test_stray();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
